// File: rtl/ysyx_23060201_mem_arb.sv
// Shares the single pmem port between the IFU (read-only) and the LSU (read/write), one access at a time.
// Define YSYX_23060201_ARB_RR_EN for round-robin arbitration on ties; the default is fixed LSU priority.
module ysyx_23060201_mem_arb #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LATENCY        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ifu_req_valid,
    output logic                      ifu_req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ifu_raddr,
    output logic                      ifu_rsp_valid,
    input  logic                      ifu_rsp_ready,
    output logic [DATA_WIDTH-1:0]     ifu_rdata,
    input  logic                      lsu_req_valid,
    output logic                      lsu_req_ready,
    input  logic                      lsu_wen,
    input  logic [MEM_ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata,
    input  logic [7:0]                lsu_mask,
    output logic                      lsu_rsp_valid,
    input  logic                      lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0]     lsu_rdata,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    output logic [7:0]                mem_rmask,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]                mem_wmask,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      busy,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_e                    state_q;
    logic                      owner_lsu_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                mask_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      wen_q;
    logic [CW-1:0]             cnt_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      gnt_ifu;
    logic                      gnt_lsu;
    logic                      rd_active;
    logic                      wr_active;
    logic                      rsp_taken;

`ifdef YSYX_23060201_ARB_RR_EN
    logic                      last_grant_q;  // 1 = LSU was granted last
`endif

    // Handshakes: a transfer happens on a posedge where valid and ready are both high;
    // req_ready is offered only in IDLE, and rsp_valid holds with stable data until rsp_ready.
    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        if (state_q == IDLE) begin
`ifdef YSYX_23060201_ARB_RR_EN
            if (ifu_req_valid && lsu_req_valid) begin
                gnt_lsu = ~last_grant_q;
                gnt_ifu = last_grant_q;
            end else begin
                gnt_lsu = lsu_req_valid;
                gnt_ifu = ifu_req_valid;
            end
`else
            gnt_lsu = lsu_req_valid;
            gnt_ifu = ifu_req_valid & ~lsu_req_valid;
`endif
        end
    end

    assign rsp_taken = owner_lsu_q ? lsu_rsp_ready : ifu_rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
`ifdef YSYX_23060201_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_lsu) begin
                        owner_lsu_q <= 1'b1;
                        addr_q      <= lsu_addr;
                        mask_q      <= lsu_mask;
                        wdata_q     <= lsu_wdata;
                        wen_q       <= lsu_wen;
                        cnt_q       <= CNT_LOAD;
                        state_q     <= ACCESS;
                    end else if (gnt_ifu) begin
                        owner_lsu_q <= 1'b0;
                        addr_q      <= ifu_raddr;
                        mask_q      <= 8'h0F;
                        wdata_q     <= '0;
                        wen_q       <= 1'b0;
                        cnt_q       <= CNT_LOAD;
                        state_q     <= ACCESS;
                    end
`ifdef YSYX_23060201_ARB_RR_EN
                    if (gnt_lsu || gnt_ifu) last_grant_q <= gnt_lsu;
`endif
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rdata_q <= wen_q ? '0 : mem_rdata;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_taken) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reads drive the port every ACCESS cycle; a write fires only in the last one so it lands exactly once.
    assign rd_active = (state_q == ACCESS) && !wen_q;
    assign wr_active = (state_q == ACCESS) && wen_q && (cnt_q == '0);

    assign mem_ren   = rd_active;
    assign mem_raddr = rd_active ? addr_q : '0;
    assign mem_rmask = rd_active ? mask_q : '0;
    assign mem_wen   = wr_active;
    assign mem_waddr = wr_active ? addr_q : '0;
    assign mem_wmask = wr_active ? mask_q : '0;
    assign mem_wdata = wr_active ? wdata_q : '0;

    assign ifu_req_ready = gnt_ifu;
    assign lsu_req_ready = gnt_lsu;
    assign ifu_rsp_valid = (state_q == RESP) && !owner_lsu_q;
    assign lsu_rsp_valid = (state_q == RESP) && owner_lsu_q;
    assign ifu_rdata     = ifu_rsp_valid ? rdata_q : '0;
    assign lsu_rdata     = lsu_rsp_valid ? rdata_q : '0;

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// Bench for ysyx_23060201_mem_arb: one instance at LATENCY=1 (index 0) and one at LATENCY=3 (index 1),
// with a pmem model whose read data encodes the address and the ACCESS beat it was sampled in.
module tb_ysyx_23060201_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef YSYX_23060201_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n         [2];
    logic          ifu_req_valid [2];
    logic          ifu_req_ready [2];
    logic [AW-1:0] ifu_raddr     [2];
    logic          ifu_rsp_valid [2];
    logic          ifu_rsp_ready [2];
    logic [DW-1:0] ifu_rdata     [2];
    logic          lsu_req_valid [2];
    logic          lsu_req_ready [2];
    logic          lsu_wen       [2];
    logic [AW-1:0] lsu_addr      [2];
    logic [DW-1:0] lsu_wdata     [2];
    logic [7:0]    lsu_mask      [2];
    logic          lsu_rsp_valid [2];
    logic          lsu_rsp_ready [2];
    logic [DW-1:0] lsu_rdata     [2];
    logic          mem_ren       [2];
    logic [AW-1:0] mem_raddr     [2];
    logic [7:0]    mem_rmask     [2];
    logic          mem_wen       [2];
    logic [AW-1:0] mem_waddr     [2];
    logic [7:0]    mem_wmask     [2];
    logic [DW-1:0] mem_wdata     [2];
    logic [DW-1:0] mem_rdata     [2];
    logic          busy          [2];
    logic [1:0]    dbg_state     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_23060201_mem_arb #(
            .MEM_ADDR_WIDTH(AW),
            .DATA_WIDTH    (DW),
            .LATENCY       (g == 0 ? 1 : 3)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .ifu_req_valid(ifu_req_valid[g]),
            .ifu_req_ready(ifu_req_ready[g]),
            .ifu_raddr    (ifu_raddr[g]),
            .ifu_rsp_valid(ifu_rsp_valid[g]),
            .ifu_rsp_ready(ifu_rsp_ready[g]),
            .ifu_rdata    (ifu_rdata[g]),
            .lsu_req_valid(lsu_req_valid[g]),
            .lsu_req_ready(lsu_req_ready[g]),
            .lsu_wen      (lsu_wen[g]),
            .lsu_addr     (lsu_addr[g]),
            .lsu_wdata    (lsu_wdata[g]),
            .lsu_mask     (lsu_mask[g]),
            .lsu_rsp_valid(lsu_rsp_valid[g]),
            .lsu_rsp_ready(lsu_rsp_ready[g]),
            .lsu_rdata    (lsu_rdata[g]),
            .mem_ren      (mem_ren[g]),
            .mem_raddr    (mem_raddr[g]),
            .mem_rmask    (mem_rmask[g]),
            .mem_wen      (mem_wen[g]),
            .mem_waddr    (mem_waddr[g]),
            .mem_wmask    (mem_wmask[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .busy         (busy[g]),
            .dbg_state    (dbg_state[g])
        );
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [33:0] exp_q  [$];  // {unit, owner_is_lsu, rdata}
    logic [72:0] wexp_q [$];  // {unit, waddr, wmask, wdata}
    logic        last_lsu [2];
    logic [7:0]  beat [2];
    logic        got;
    logic        exp_lsu;

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_model(input logic [31:0] a, input logic [7:0] b);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], 8'h00, b};
    endfunction

    // pmem model: read data changes each beat so the returned value pins down the sampling cycle
    always_comb begin
        for (int u = 0; u < 2; u++) mem_rdata[u] = mem_model(mem_raddr[u], beat[u]);
    end

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) beat[u] <= (mem_ren[u] === 1'b1) ? beat[u] + 8'd1 : 8'd0;
    end

    task automatic push_exp(input int u, input logic lsu, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] mask);
        if (lsu && wen) begin
            exp_q.push_back({u[0], 1'b1, 32'h0});
            wexp_q.push_back({u[0], addr, mask, wdata});
        end else begin
            exp_q.push_back({u[0], lsu, mem_model(addr, 8'(lat_of(u) - 1))});
        end
    endtask

    task automatic pop_rsp(input int u, input logic own, input logic [31:0] d);
        logic [33:0] e;
        check("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_data", {u[0], own, d}, e);
        end
    endtask

    task automatic pop_wr(input int u);
        logic [72:0] e;
        check("wr_expected", wexp_q.size() > 0, 1);
        if (wexp_q.size() > 0) begin
            e = wexp_q.pop_front();
            check("wr_beat", {u[0], mem_waddr[u], mem_wmask[u], mem_wdata[u]}, e);
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (ifu_rsp_valid[u] && ifu_rsp_ready[u]) pop_rsp(u, 1'b0, ifu_rdata[u]);
            if (lsu_rsp_valid[u] && lsu_rsp_ready[u]) pop_rsp(u, 1'b1, lsu_rdata[u]);
            if (mem_wen[u]) pop_wr(u);
            if (!mem_ren[u]) check("rd_port_zero", {mem_raddr[u], mem_rmask[u]}, '0);
            if (!mem_wen[u]) check("wr_port_zero", {mem_waddr[u], mem_wmask[u], mem_wdata[u]}, '0);
            if (!ifu_rsp_valid[u]) check("ifu_rdata_zero", ifu_rdata[u], '0);
            if (!lsu_rsp_valid[u]) check("lsu_rdata_zero", lsu_rdata[u], '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int u, input logic lsu, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [7:0] mask, input logic track);
        logic rdy;
        if (lsu) begin
            lsu_req_valid[u] = 1'b1;
            lsu_wen[u]       = wen;
            lsu_addr[u]      = addr;
            lsu_wdata[u]     = wdata;
            lsu_mask[u]      = mask;
        end else begin
            ifu_req_valid[u] = 1'b1;
            ifu_raddr[u]     = addr;
        end
        #1;
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            rdy = lsu ? lsu_req_ready[u] : ifu_req_ready[u];
            if (!rdy) step();
        end
        check("req_ready", rdy, 1);
        if (rdy && track) push_exp(u, lsu, wen, addr, wdata, mask);
        if (rdy) last_lsu[u] = lsu;
        @(posedge clk);
        #1;
        ifu_req_valid[u] = 1'b0;
        lsu_req_valid[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        for (int i = 0; i < 100; i++) begin
            if (!busy[u] && exp_q.size() == 0 && wexp_q.size() == 0) break;
            step();
        end
        check("drain", {busy[u], exp_q.size() == 0, wexp_q.size() == 0}, 3'b011);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            ifu_req_valid[u] = 1'b0; ifu_raddr[u] = '0; ifu_rsp_ready[u] = 1'b1;
            lsu_req_valid[u] = 1'b0; lsu_wen[u] = 1'b0; lsu_addr[u] = '0;
            lsu_wdata[u] = '0; lsu_mask[u] = '0; lsu_rsp_ready[u] = 1'b1;
            last_lsu[u] = 1'b0;
        end
        repeat (3) step();
        for (int u = 0; u < 2; u++) begin
            check("reset_state", {busy[u], dbg_state[u], mem_ren[u], mem_wen[u],
                                  ifu_rsp_valid[u], lsu_rsp_valid[u]}, '0);
            rst_n[u] = 1'b1;
        end
        step();

        // LSU write at LATENCY=1: one write beat, no read, response carries 0
        issue(0, 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h03, 1'b1);
        check("wr_wen", {mem_wen[0], mem_ren[0], mem_waddr[0], mem_wmask[0], mem_wdata[0]},
              {1'b1, 1'b0, 32'h8000_1000, 8'h03, 32'hDEAD_BEEF});
        step();
        check("wr_rsp", {lsu_rsp_valid[0], lsu_rdata[0], mem_wen[0]}, {1'b1, 32'h0, 1'b0});
        wait_idle(0);

        // IFU read at LATENCY=1
        issue(0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 1'b1);
        check("ifu_access", {mem_ren[0], mem_raddr[0], mem_rmask[0], ifu_rsp_valid[0]},
              {1'b1, 32'h8000_0000, 8'h0F, 1'b0});
        step();
        check("ifu_rsp", {ifu_rsp_valid[0], ifu_rdata[0]}, {1'b1, 32'h0000_0413});
        wait_idle(0);
        issue(0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 8'h00, 1'b1);
        wait_idle(0);

        // Tie with IFU granted last: LSU wins in either mode, IFU waits for the LSU response
        ifu_req_valid[0] = 1'b1; ifu_raddr[0] = 32'h8000_0020;
        lsu_req_valid[0] = 1'b1; lsu_wen[0] = 1'b0; lsu_addr[0] = 32'h8000_0030; lsu_mask[0] = 8'hFF;
        #1;
        check("tie_first", {ifu_req_ready[0], lsu_req_ready[0]}, 2'b01);
        push_exp(0, 1'b1, 1'b0, 32'h8000_0030, 32'h0, 8'hFF);
        last_lsu[0] = 1'b1;
        step();
        lsu_req_valid[0] = 1'b0;
        #1;
        check("ifu_wait_access", ifu_req_ready[0], 0);
        step();
        check("ifu_wait_resp", {ifu_req_ready[0], lsu_rsp_valid[0]}, 2'b01);
        step();
        check("ifu_granted", ifu_req_ready[0], 1);
        push_exp(0, 1'b0, 1'b0, 32'h8000_0020, 32'h0, 8'h0F);
        last_lsu[0] = 1'b0;
        step();
        ifu_req_valid[0] = 1'b0;
        wait_idle(0);

        // Continuous contention: three grants
        ifu_req_valid[0] = 1'b1; ifu_raddr[0] = 32'h8000_0044;
        lsu_req_valid[0] = 1'b1; lsu_addr[0] = 32'h8000_0048;
        #1;
        for (int g = 0; g < 3; g++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                got = ifu_req_ready[0] | lsu_req_ready[0];
                if (!got) step();
            end
            exp_lsu = RR ? !last_lsu[0] : 1'b1;
            check("contend_grant", {ifu_req_ready[0], lsu_req_ready[0]}, {!exp_lsu, exp_lsu});
            push_exp(0, exp_lsu, 1'b0, exp_lsu ? 32'h8000_0048 : 32'h8000_0044, 32'h0, 8'hFF);
            last_lsu[0] = exp_lsu;
            step();
            if (g == 2) begin
                ifu_req_valid[0] = 1'b0;
                lsu_req_valid[0] = 1'b0;
            end else begin
                check("no_ready_busy", {ifu_req_ready[0], lsu_req_ready[0]}, 2'b00);
            end
        end
        wait_idle(0);

        // Back-pressure in RESP: held data, idle memory port, no grant to the other side
        lsu_rsp_ready[0] = 1'b0;
        issue(0, 1'b1, 1'b0, 32'h8000_0050, 32'h0, 8'h0F, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            ifu_req_valid[0] = 1'b1; ifu_raddr[0] = 32'h8000_0060;
            #1;
            check("hold_rsp", {lsu_rsp_valid[0], lsu_rdata[0], mem_ren[0], mem_wen[0], busy[0],
                               ifu_req_ready[0]}, {1'b1, 32'h0050_0000, 1'b0, 1'b0, 1'b1, 1'b0});
            step();
        end
        ifu_req_valid[0] = 1'b0;
        lsu_rsp_ready[0] = 1'b1;
        wait_idle(0);

        // LATENCY=3: write only in the third ACCESS cycle
        issue(1, 1'b1, 1'b1, 32'h8000_2000, 32'h1234_5678, 8'hF0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("lat3_wen", {mem_wen[1], mem_ren[1]}, {(c == 2), 1'b0});
            step();
        end
        wait_idle(1);
        // LATENCY=3 read: port active for three cycles, third-beat data returned
        issue(1, 1'b1, 1'b0, 32'h8000_2004, 32'h0, 8'h3C, 1'b1);
        for (int c = 0; c < 3; c++) begin
            check("lat3_ren", {mem_ren[1], mem_raddr[1], mem_rmask[1]}, {1'b1, 32'h8000_2004, 8'h3C});
            step();
        end
        check("lat3_rsp", {lsu_rsp_valid[1], lsu_rdata[1]}, {1'b1, 32'h2004_0002});
        wait_idle(1);
        issue(1, 1'b0, 1'b0, 32'h8000_2008, 32'h0, 8'h00, 1'b1);
        wait_idle(1);

        // Reset in the first ACCESS cycle of a write: aborted, nothing reaches memory
        issue(1, 1'b1, 1'b1, 32'h8000_3000, 32'hBAD0_BAD0, 8'hFF, 1'b0);
        rst_n[1] = 1'b0;
        last_lsu[1] = 1'b0;
        #1;
        check("abort_outputs", {busy[1], dbg_state[1], mem_wen[1], mem_ren[1], lsu_rsp_valid[1],
                                mem_waddr[1], mem_wdata[1]}, '0);
        repeat (4) step();
        rst_n[1] = 1'b1;
        step();
        check("after_abort", {busy[1], dbg_state[1]}, '0);
        issue(1, 1'b1, 1'b1, 32'h8000_3000, 32'hCAFE_F00D, 8'hFF, 1'b1);
        wait_idle(1);
        issue(1, 1'b1, 1'b0, 32'h8000_3000, 32'h0, 8'hFF, 1'b1);
        wait_idle(1);

        repeat (3) step();
        check("queues_empty", {exp_q.size(), wexp_q.size()}, '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060201_mem_arb.md
Name: ysyx_23060201_mem_arb

Overview:
Arbiter and sequencer sharing the single physical-memory port (pmem DPI memory block) between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). Accepts one request at a time over valid/ready handshakes and drives the memory port for a parameterised access latency. Returns the result to the owning requester over a valid/ready response channel. Sits between IFU/LSU and the memory block.

Parameters:
MEM_ADDR_WIDTH, 32, address width of requests and memory port
DATA_WIDTH, 32, data width
LATENCY, 1, memory-port cycles per access; must be >= 1 (0 is illegal)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_raddr  in  MEM_ADDR_WIDTH  IFU read address
ifu_rsp_valid  out  1  IFU response valid
ifu_rsp_ready  in  1  IFU response accepted
ifu_rdata  out  DATA_WIDTH  IFU read data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1 = write, 0 = read
lsu_addr  in  MEM_ADDR_WIDTH  LSU address
lsu_wdata  in  DATA_WIDTH  LSU write data
lsu_mask  in  8  LSU byte mask
lsu_rsp_valid  out  1  LSU response valid
lsu_rsp_ready  in  1  LSU response accepted
lsu_rdata  out  DATA_WIDTH  LSU read data (0 for writes)
mem_ren  out  1  memory read enable
mem_raddr  out  MEM_ADDR_WIDTH  memory read address
mem_rmask  out  8  memory read mask
mem_wen  out  1  memory write enable (memory writes on posedge)
mem_waddr  out  MEM_ADDR_WIDTH  memory write address
mem_wmask  out  8  memory write mask
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (async, rst_n=0): state IDLE, all outputs 0, latched request/data registers 0, counter 0.
- IDLE: req_ready is combinational and asserted only for the granted requester, only when its req_valid=1. Default arbitration is fixed priority: LSU over IFU. On handshake: latch owner, addr, mask (IFU mask fixed 8'h0F), wdata, wen (IFU wen=0). Load cnt=LATENCY-1. Next state ACCESS.
- ACCESS (LATENCY cycles): read: mem_ren=1 with latched addr/mask on mem_raddr/mem_rmask every ACCESS cycle. Write: mem_wen=1 only in the final ACCESS cycle (cnt==0), with mem_waddr/mem_wmask/mem_wdata from latched values. Exactly one write per accepted write request. When cnt != 0, decrement cnt. When cnt == 0, capture mem_rdata into rdata register for a read (0 for a write) at the closing posedge, then go to RESP.
- Unused mem_* address/data/mask outputs are 0 whenever their enable is 0.
- RESP: owner's rsp_valid=1 and rdata held stable until rsp_ready=1, then IDLE. Non-owner rsp_valid=0 and rdata=0.
- No req_ready outside IDLE. A new request can be accepted in the cycle after the response handshake.
- Timing: accept at cycle T. ACCESS occupies T+1..T+LATENCY. rsp_valid is first high at T+LATENCY+1. Minimum issue interval is LATENCY+2 cycles.
- Counter width: $clog2(LATENCY)+1 bits; no wrap occurs.
- Reset mid-operation: transaction is aborted immediately. If the reset arrives before the final ACCESS posedge, no mem_wen is issued. No response is delivered.
- req_valid dropping before acceptance has no effect on arbiter state.

Optional Feature:
YSYX_23060201_ARB_RR_EN: defined -> round-robin arbitration on simultaneous requests. A 1-bit last_grant register updates on each request handshake. On a tie, the requester not last granted wins. Reset value of last_grant is IFU, so the LSU wins the first tie. A single requester is always granted. Not defined -> fixed LSU priority and no last_grant register.

Test Plan:
1. LATENCY=1, IFU read at 0x80000000, mem_rdata=0x00000413 -> ifu_req_ready at T. mem_ren=1, mem_raddr=0x80000000, mem_rmask=0x0F at T+1. ifu_rsp_valid=1 with ifu_rdata=0x00000413 at T+2.
2. LSU write addr 0x80001000, wdata 0xDEADBEEF, mask 0x03 -> mem_wen high exactly one cycle with those values. mem_ren stays 0. lsu_rsp_valid=1 with lsu_rdata=0.
3. IFU and LSU valid in the same cycle (macro off) -> LSU granted. ifu_req_ready=0 until the LSU response handshake, then IFU is granted in the next IDLE cycle. With the macro on, under continuous contention, grants alternate LSU, IFU, LSU.
4. rsp_ready held low for 5 cycles in RESP -> rsp_valid and rdata stable. mem_ren=mem_wen=0. No req_ready given to the other requester. busy=1.
5. LATENCY=3, LSU write -> mem_wen only in the 3rd ACCESS cycle. LSU read -> mem_ren high for 3 cycles, and the value sampled in the 3rd cycle is returned.
6. rst_n pulsed low in the first ACCESS cycle of a write at LATENCY=3 -> all outputs 0 immediately, no mem_wen ever seen. After release: IDLE, and a fresh request completes normally.
